apb_arb2: RTL and testbench
===========================

Name: apb_arb2

Overview:
- Two-requester APB arbiter in front of the single debugger APB completer (5-bit address, 8-bit data).
- Requester 0 is the I2C-to-APB bridge; requester 1 is a second host bridge (e.g. SPI or JTAG-lite).
- Each requester sees a normal APB completer port. The arbiter serialises their transfers onto one APB requester port.
- Fairness is round-robin, and a watchdog timeout prevents a hung completer from locking both hosts.

Parameters:
ADDR_W, 5, APB address width.
DATA_W, 8, APB data width.
TIMEOUT, 255, max downstream ACCESS cycles before abort; 0 disables the watchdog.

Ports:
PCLK  in  1  clock, all state on rising edge
PRESET  in  1  synchronous active-high reset
S0_PSEL  in  1  requester 0 select
S0_PADDR  in  ADDR_W  requester 0 address
S0_PENABLE  in  1  requester 0 enable
S0_PWRITE  in  1  requester 0 write
S0_PWDATA  in  DATA_W  requester 0 write data
S0_PRDATA  out  DATA_W  requester 0 read data
S0_PREADY  out  1  requester 0 ready
S0_PSLVERR  out  1  requester 0 error
S1_*  same set of 8 signals as S0_*, for requester 1
M_PSEL  out  1  downstream select
M_PADDR  out  ADDR_W  downstream address
M_PENABLE  out  1  downstream enable
M_PWRITE  out  1  downstream write
M_PWDATA  out  DATA_W  downstream write data
M_PRDATA  in  DATA_W  downstream read data
M_PREADY  in  1  downstream ready
GNT  out  1  index of the current or last granted requester

Behaviour:
- Reset (PRESET=1 at an edge):
  - State goes to IDLE and the round-robin pointer is cleared so requester 0 wins the first tie.
  - All outputs go to 0: M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, Sx_PREADY, Sx_PSLVERR, Sx_PRDATA, GNT.
  - Reset mid-transfer aborts immediately. Downstream PSEL drops the next cycle, and no PREADY is issued upstream.
- All outputs are registered; no combinational paths from inputs to outputs.
- State machine, one state per cycle:
  - IDLE:
    - Requester i is pending when Sx_PSEL=1 and Sx_PREADY is not being asserted this cycle.
    - If exactly one is pending, grant it.
    - If both are pending, grant the one not equal to the last-served index.
    - On grant: latch that requester's PADDR, PWRITE and PWDATA into M_*, set GNT, and go to SETUP.
  - SETUP: M_PSEL=1, M_PENABLE=0. Next state is ACCESS.
  - ACCESS:
    - M_PSEL=1, M_PENABLE=1, watchdog counter increments each cycle.
    - On M_PREADY=1: capture M_PRDATA, go to DONE.
    - When TIMEOUT≠0 and the counter reaches TIMEOUT without M_PREADY: go to DONE with the error flag set, and PRDATA forced to all-ones.
  - DONE:
    - M_PSEL=0, M_PENABLE=0.
    - Granted Sx_PREADY=1 for exactly one cycle, with Sx_PRDATA=captured data and Sx_PSLVERR=error flag.
    - Update the last-served pointer to GNT, clear the counter, return to IDLE.
- Outside DONE, Sx_PREADY=0 and Sx_PSLVERR=0. Sx_PRDATA holds its last value.
- Latency:
  - Request seen in IDLE at cycle T gives downstream SETUP at T+1 and ACCESS at T+2.
  - Zero-wait completer gives upstream PREADY at T+3.
  - Each downstream wait state adds one cycle.
- The losing requester simply sees PREADY=0 (APB wait states) until it is served. Its signals must stay stable per APB.
- Requester drops PSEL mid-transfer (protocol violation):
  - The downstream transfer still completes normally, and the pointer still updates.
  - Sx_PREADY is still pulsed; the requester ignores it.
- Back-to-back transfers from the same requester with no competitor are served without penalty beyond the IDLE cycle (4-cycle minimum per transfer).
- The watchdog counter width is clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Single read, zero wait: S0 reads addr 5'h03 and completer returns 8'hA5 with PREADY in its first ACCESS cycle → M_PSEL high at T+1, M_PENABLE at T+2, S0_PREADY=1 with S0_PRDATA=8'hA5 and PSLVERR=0 at T+3, S1_PREADY stays 0.
- Write with waits: S1 writes 8'h5C to 5'h10 and completer inserts 3 wait states → M_PADDR=5'h10, M_PWRITE=1 and M_PWDATA=8'h5C stable through ACCESS; S1_PREADY pulses once at T+6.
- Simultaneous requests after reset, repeated 4×: both assert PSEL in the same cycle each time → grant order 0,1,0,1 and GNT matches each downstream transfer, with no overlap of M_PSEL windows.
- Timeout: TIMEOUT=4, completer never asserts PREADY → after 4 ACCESS cycles M_PSEL drops, and S0_PREADY=1, S0_PSLVERR=1, S0_PRDATA=8'hFF. A following normal transfer completes with PSLVERR=0.
- Reset mid-ACCESS: assert PRESET during a pending S1 read → next cycle M_PSEL=0, no Sx_PREADY pulse, GNT=0. A post-reset tie is granted to S0.
- Requester abort: S0 drops PSEL during SETUP → downstream transfer still completes, and a pending S1 is then granted normally.

Source files
------------

// File: rtl/apb_arb2.sv
// Two-requester APB arbiter: round-robin serialisation of two APB completer ports onto one
// downstream APB requester port, with a watchdog that aborts hung downstream transfers.
module apb_arb2 #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              S0_PSEL,
    input  logic [ADDR_W-1:0] S0_PADDR,
    input  logic              S0_PENABLE,
    input  logic              S0_PWRITE,
    input  logic [DATA_W-1:0] S0_PWDATA,
    output logic [DATA_W-1:0] S0_PRDATA,
    output logic              S0_PREADY,
    output logic              S0_PSLVERR,
    input  logic              S1_PSEL,
    input  logic [ADDR_W-1:0] S1_PADDR,
    input  logic              S1_PENABLE,
    input  logic              S1_PWRITE,
    input  logic [DATA_W-1:0] S1_PWDATA,
    output logic [DATA_W-1:0] S1_PRDATA,
    output logic              S1_PREADY,
    output logic              S1_PSLVERR,
    output logic              M_PSEL,
    output logic [ADDR_W-1:0] M_PADDR,
    output logic              M_PENABLE,
    output logic              M_PWRITE,
    output logic [DATA_W-1:0] M_PWDATA,
    input  logic [DATA_W-1:0] M_PRDATA,
    input  logic              M_PREADY,
    output logic              GNT
);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e            state_q;
    logic              prio_q;
    logic [CntW-1:0]   cnt_q;
    logic              gnt_q;
    logic              m_psel_q;
    logic              m_penable_q;
    logic              m_pwrite_q;
    logic [ADDR_W-1:0] m_paddr_q;
    logic [DATA_W-1:0] m_pwdata_q;
    logic              s0_pready_q;
    logic              s0_pslverr_q;
    logic [DATA_W-1:0] s0_prdata_q;
    logic              s1_pready_q;
    logic              s1_pslverr_q;
    logic [DATA_W-1:0] s1_prdata_q;

    logic pend0;
    logic pend1;
    logic pick;
    logic timeout_hit;

    // prio_q names the requester that wins a tie; it flips away from whoever was last served.
    always_comb begin
        pend0       = S0_PSEL & ~s0_pready_q;
        pend1       = S1_PSEL & ~s1_pready_q;
        pick        = (pend0 & pend1) ? prio_q : pend1;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= 1'b0;
            m_psel_q     <= 1'b0;
            m_penable_q  <= 1'b0;
            m_pwrite_q   <= 1'b0;
            m_paddr_q    <= '0;
            m_pwdata_q   <= '0;
            s0_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s0_prdata_q  <= '0;
            s1_pready_q  <= 1'b0;
            s1_pslverr_q <= 1'b0;
            s1_prdata_q  <= '0;
        end else begin
            s0_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s1_pready_q  <= 1'b0;
            s1_pslverr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pend0 | pend1) begin
                        gnt_q      <= pick;
                        m_paddr_q  <= pick ? S1_PADDR : S0_PADDR;
                        m_pwrite_q <= pick ? S1_PWRITE : S0_PWRITE;
                        m_pwdata_q <= pick ? S1_PWDATA : S0_PWDATA;
                        m_psel_q   <= 1'b1;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    m_penable_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= StAccess;
                end
                StAccess: begin
                    // A completer answering on the last allowed cycle still wins over the watchdog.
                    if (M_PREADY || timeout_hit) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        state_q     <= StDone;
                        if (gnt_q) begin
                            s1_pready_q  <= 1'b1;
                            s1_pslverr_q <= ~M_PREADY;
                            s1_prdata_q  <= M_PREADY ? M_PRDATA : '1;
                        end else begin
                            s0_pready_q  <= 1'b1;
                            s0_pslverr_q <= ~M_PREADY;
                            s0_prdata_q  <= M_PREADY ? M_PRDATA : '1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    prio_q  <= ~gnt_q;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign M_PSEL     = m_psel_q;
    assign M_PENABLE  = m_penable_q;
    assign M_PWRITE   = m_pwrite_q;
    assign M_PADDR    = m_paddr_q;
    assign M_PWDATA   = m_pwdata_q;
    assign GNT        = gnt_q;
    assign S0_PREADY  = s0_pready_q;
    assign S0_PSLVERR = s0_pslverr_q;
    assign S0_PRDATA  = s0_prdata_q;
    assign S1_PREADY  = s1_pready_q;
    assign S1_PSLVERR = s1_pslverr_q;
    assign S1_PRDATA  = s1_prdata_q;

endmodule

// File: tb/tb_apb_arb2.sv
// Bench for apb_arb2: directed and random transfer pairs checked against a cycle-level
// reference model of grant order, latency, data and error responses.
module tb_apb_arb2;
    localparam int unsigned TO = 4;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       S0_PSEL, S0_PENABLE, S0_PWRITE, S0_PREADY, S0_PSLVERR;
    logic [4:0] S0_PADDR;
    logic [7:0] S0_PWDATA, S0_PRDATA;
    logic       S1_PSEL, S1_PENABLE, S1_PWRITE, S1_PREADY, S1_PSLVERR;
    logic [4:0] S1_PADDR;
    logic [7:0] S1_PWDATA, S1_PRDATA;
    logic       M_PSEL, M_PENABLE, M_PWRITE, M_PREADY, GNT;
    logic [4:0] M_PADDR;
    logic [7:0] M_PWDATA, M_PRDATA;

    apb_arb2 #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .S0_PSEL(S0_PSEL), .S0_PADDR(S0_PADDR), .S0_PENABLE(S0_PENABLE),
        .S0_PWRITE(S0_PWRITE), .S0_PWDATA(S0_PWDATA), .S0_PRDATA(S0_PRDATA),
        .S0_PREADY(S0_PREADY), .S0_PSLVERR(S0_PSLVERR),
        .S1_PSEL(S1_PSEL), .S1_PADDR(S1_PADDR), .S1_PENABLE(S1_PENABLE),
        .S1_PWRITE(S1_PWRITE), .S1_PWDATA(S1_PWDATA), .S1_PRDATA(S1_PRDATA),
        .S1_PREADY(S1_PREADY), .S1_PSLVERR(S1_PSLVERR),
        .M_PSEL(M_PSEL), .M_PADDR(M_PADDR), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .GNT(GNT)
    );

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] wd;
        logic       gnt;
        int         cyc;
    } xfer_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tie_winner = 0;

    // Per-requester transfer description; the completer looks its behaviour up by address.
    logic [4:0] q_addr [2];
    logic       q_wr   [2];
    logic [7:0] q_wd   [2];
    int         q_wait [2];
    logic [7:0] q_rd   [2];

    xfer_t      log_q [$];
    int         en_q [$];
    int         pulses [2] = '{0, 0};
    int         done_cyc [2] = '{0, 0};
    logic [7:0] done_data [2];
    logic       done_err [2];
    int         stray_err = 0;
    int         unstable = 0;
    int         acc_cnt = 0;
    logic       prev_pen = 1'b0;
    int         mon_idx;
    xfer_t      mon_x;

    initial forever #5 PCLK = ~PCLK;

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // Completer model plus monitor, evaluated mid-cycle.
    initial forever begin
        @(negedge PCLK);
        if (S0_PREADY === 1'b1) begin
            pulses[0]++; done_cyc[0] = cyc; done_data[0] = S0_PRDATA; done_err[0] = S0_PSLVERR;
        end
        if (S1_PREADY === 1'b1) begin
            pulses[1]++; done_cyc[1] = cyc; done_data[1] = S1_PRDATA; done_err[1] = S1_PSLVERR;
        end
        if (S0_PREADY !== 1'b1 && S0_PSLVERR === 1'b1) stray_err++;
        if (S1_PREADY !== 1'b1 && S1_PSLVERR === 1'b1) stray_err++;
        if (M_PENABLE === 1'b1 && M_PSEL !== 1'b1) unstable++;
        if (M_PSEL === 1'b1 && M_PENABLE === 1'b0) begin
            mon_x.addr = M_PADDR; mon_x.wr = M_PWRITE; mon_x.wd = M_PWDATA;
            mon_x.gnt = GNT; mon_x.cyc = cyc;
            log_q.push_back(mon_x);
        end
        if (M_PSEL === 1'b1 && M_PENABLE === 1'b1) begin
            if (!prev_pen) en_q.push_back(cyc);
            if (log_q.size() == 0) unstable++;
            else if (M_PADDR !== mon_x.addr || M_PWRITE !== mon_x.wr || M_PWDATA !== mon_x.wd)
                unstable++;
            mon_idx = (M_PADDR == q_addr[1]) ? 1 : 0;
            M_PREADY = (acc_cnt >= q_wait[mon_idx]);
            M_PRDATA = q_rd[mon_idx];
            acc_cnt++;
            prev_pen = 1'b1;
        end else begin
            M_PREADY = 1'b0;
            acc_cnt = 0;
            prev_pen = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int acc_cycles(input int w);
        return (w >= int'(TO)) ? int'(TO) : w + 1;
    endfunction

    task automatic set_cfg(input int i, input logic [4:0] a, input logic wr, input logic [7:0] wd,
                           input int w, input logic [7:0] rd);
        q_addr[i] = a; q_wr[i] = wr; q_wd[i] = wd; q_wait[i] = w; q_rd[i] = rd;
    endtask

    task automatic drive_req(input int i);
        if (i == 0) begin
            S0_PSEL = 1'b1; S0_PENABLE = 1'b0;
            S0_PADDR = q_addr[0]; S0_PWRITE = q_wr[0]; S0_PWDATA = q_wd[0];
        end else begin
            S1_PSEL = 1'b1; S1_PENABLE = 1'b0;
            S1_PADDR = q_addr[1]; S1_PWRITE = q_wr[1]; S1_PWDATA = q_wd[1];
        end
    endtask

    // Issue one transfer per enabled requester and check the whole exchange against the model.
    task automatic run(input logic en0, input logic en1, input int dly1, input logic abort0,
                       input string tag);
        int start, base_log, base_en, b0, b1, t, n, i, dp;
        int order [$];
        int exp_done [2];
        int exp_setup [2];
        logic en;
        logic exp_err;
        logic [7:0] exp_data;
        xfer_t x;

        base_log = log_q.size(); base_en = en_q.size(); b0 = pulses[0]; b1 = pulses[1];
        start = cyc;
        if (en0) drive_req(0);
        if (en1 && dly1 == 0) drive_req(1);

        if (en0 && en1 && dly1 == 0) begin
            order.push_back(tie_winner);
            order.push_back(1 - tie_winner);
        end else begin
            if (en0) order.push_back(0);
            if (en1) order.push_back(1);
        end
        t = start;
        foreach (order[k]) begin
            i = order[k];
            if (i == 1 && t < start + dly1) t = start + dly1;
            exp_setup[i] = t + 1;
            exp_done[i] = t + 2 + acc_cycles(q_wait[i]);
            t = exp_done[i] + 1;
            tie_winner = 1 - i;
        end

        n = 0;
        while (((pulses[0] - b0) < int'(en0) || (pulses[1] - b1) < int'(en1)) && n < 60) begin
            @(posedge PCLK); #1;
            n++;
            if (pulses[0] != b0) begin S0_PSEL = 1'b0; S0_PENABLE = 1'b0; end
            else if (S0_PSEL) S0_PENABLE = 1'b1;
            if (pulses[1] != b1) begin S1_PSEL = 1'b0; S1_PENABLE = 1'b0; end
            else if (S1_PSEL) S1_PENABLE = 1'b1;
            if (abort0 && cyc == start + 1) begin S0_PSEL = 1'b0; S0_PENABLE = 1'b0; end
            if (en1 && dly1 > 0 && cyc == start + dly1) drive_req(1);
        end
        chk($sformatf("%s budget", tag), 32'(n >= 60), 32'd0);
        S0_PSEL = 1'b0; S0_PENABLE = 1'b0; S1_PSEL = 1'b0; S1_PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;

        for (int r = 0; r < 2; r++) begin
            en = (r == 1) ? en1 : en0;
            dp = pulses[r] - ((r == 1) ? b1 : b0);
            chk($sformatf("%s s%0d pulses", tag, r), 32'(dp), 32'(en));
            if (en) begin
                exp_err = (q_wait[r] >= int'(TO));
                exp_data = exp_err ? 8'hFF : q_rd[r];
                chk($sformatf("%s s%0d ready_cyc", tag, r), 32'(done_cyc[r]),
                    32'(exp_done[r]));
                chk($sformatf("%s s%0d prdata", tag, r), 32'(done_data[r]), 32'(exp_data));
                chk($sformatf("%s s%0d pslverr", tag, r), 32'(done_err[r]), 32'(exp_err));
            end
        end
        chk($sformatf("%s xfer count", tag), 32'(log_q.size() - base_log), 32'(order.size()));
        chk($sformatf("%s enable count", tag), 32'(en_q.size() - base_en), 32'(order.size()));
        foreach (order[k]) begin
            i = order[k];
            if (base_log + k < log_q.size() && base_en + k < en_q.size()) begin
                x = log_q[base_log + k];
                chk($sformatf("%s x%0d gnt", tag, k), 32'(x.gnt), 32'(i));
                chk($sformatf("%s x%0d paddr", tag, k), 32'(x.addr), 32'(q_addr[i]));
                chk($sformatf("%s x%0d pwrite", tag, k), 32'(x.wr), 32'(q_wr[i]));
                chk($sformatf("%s x%0d pwdata", tag, k), 32'(x.wd), 32'(q_wd[i]));
                chk($sformatf("%s x%0d setup_cyc", tag, k), 32'(x.cyc), 32'(exp_setup[i]));
                chk($sformatf("%s x%0d access_cyc", tag, k), 32'(en_q[base_en + k]),
                    32'(exp_setup[i] + 1));
            end
        end
        chk($sformatf("%s gnt after", tag), 32'(GNT), 32'(order[order.size() - 1]));
        chk($sformatf("%s m_psel idle", tag), 32'(M_PSEL), 32'd0);
        chk($sformatf("%s stray pslverr", tag), 32'(stray_err), 32'd0);
        chk($sformatf("%s m_* unstable", tag), 32'(unstable), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int b0, b1, start, m;
        logic [4:0] a;

        PRESET = 1'b1;
        S0_PSEL = 1'b0; S0_PENABLE = 1'b0; S0_PWRITE = 1'b0; S0_PADDR = '0; S0_PWDATA = '0;
        S1_PSEL = 1'b0; S1_PENABLE = 1'b0; S1_PWRITE = 1'b0; S1_PADDR = '0; S1_PWDATA = '0;
        set_cfg(0, 5'h03, 1'b0, 8'h00, 0, 8'h00);
        set_cfg(1, 5'h13, 1'b0, 8'h00, 0, 8'h00);
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst m_psel", 32'(M_PSEL), 32'd0);
        chk("rst m_penable", 32'(M_PENABLE), 32'd0);
        chk("rst m_pwrite", 32'(M_PWRITE), 32'd0);
        chk("rst m_paddr", 32'(M_PADDR), 32'd0);
        chk("rst m_pwdata", 32'(M_PWDATA), 32'd0);
        chk("rst gnt", 32'(GNT), 32'd0);
        chk("rst s0 ready/err/data", 32'({S0_PREADY, S0_PSLVERR, S0_PRDATA}), 32'd0);
        chk("rst s1 ready/err/data", 32'({S1_PREADY, S1_PSLVERR, S1_PRDATA}), 32'd0);
        PRESET = 1'b0;
        tie_winner = 0;

        set_cfg(0, 5'h03, 1'b0, 8'h00, 0, 8'hA5);
        run(1'b1, 1'b0, 0, 1'b0, "read0");

        set_cfg(1, 5'h10, 1'b1, 8'h5C, 3, 8'h00);
        run(1'b0, 1'b1, 0, 1'b0, "write1");

        for (int k = 0; k < 4; k++) begin
            set_cfg(0, 5'(k), 1'b0, 8'h00, k % 3, 8'(8'h30 + k));
            set_cfg(1, 5'(5'h18 + k), 1'b1, 8'(8'hC0 + k), (k + 1) % 3, 8'(8'h60 + k));
            run(1'b1, 1'b1, 0, 1'b0, $sformatf("tie%0d", k));
        end

        set_cfg(0, 5'h07, 1'b0, 8'h00, 100, 8'h3C);
        run(1'b1, 1'b0, 0, 1'b0, "timeout");
        set_cfg(0, 5'h07, 1'b0, 8'h00, 1, 8'h42);
        run(1'b1, 1'b0, 0, 1'b0, "after_timeout");

        // Hang S1 in ACCESS, then reset under it.
        set_cfg(1, 5'h0A, 1'b0, 8'h00, 100, 8'h77);
        b0 = pulses[0]; b1 = pulses[1];
        start = cyc;
        drive_req(1);
        repeat (3) begin
            @(posedge PCLK); #1;
            if (S1_PSEL) S1_PENABLE = 1'b1;
        end
        chk("rst_mid in access", 32'({M_PSEL, M_PENABLE, GNT}), 32'b111);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; S1_PSEL = 1'b0; S1_PENABLE = 1'b0;
        chk("rst_mid m_psel", 32'(M_PSEL), 32'd0);
        chk("rst_mid m_penable", 32'(M_PENABLE), 32'd0);
        chk("rst_mid gnt", 32'(GNT), 32'd0);
        repeat (6) @(posedge PCLK);
        #1;
        chk("rst_mid s0 pulses", 32'(pulses[0] - b0), 32'd0);
        chk("rst_mid s1 pulses", 32'(pulses[1] - b1), 32'd0);
        tie_winner = 0;
        set_cfg(0, 5'h01, 1'b1, 8'h11, 0, 8'h21);
        set_cfg(1, 5'h02, 1'b0, 8'h00, 2, 8'h22);
        run(1'b1, 1'b1, 0, 1'b0, "post_rst_tie");

        set_cfg(0, 5'h04, 1'b0, 8'h00, 1, 8'h9E);
        set_cfg(1, 5'h05, 1'b1, 8'hE7, 0, 8'h5A);
        run(1'b1, 1'b1, 1, 1'b1, "abort0");

        for (int it = 0; it < 24; it++) begin
            m = int'($urandom_range(3, 1));
            a = 5'($urandom);
            set_cfg(0, a, 1'($urandom), 8'($urandom), int'($urandom_range(5, 0)), 8'($urandom));
            set_cfg(1, a ^ 5'h10, 1'($urandom), 8'($urandom), int'($urandom_range(5, 0)),
                    8'($urandom));
            run(m[0], m[1], 0, 1'b0, $sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
